// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-stage controller.
package mem_stage_pkg;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and writeback signals of the memory stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic              ex_valid;
   logic [DATA_W-1:0] ALUO;
   logic [DATA_W-1:0] Rd2;
   logic              mem_read;
   logic              mem_write;
   logic              mem_en;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_stall;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_data;
   logic              err;

   modport master (
      input  ex_valid, ALUO, Rd2, mem_read, mem_write,
      input  mem_stall, mem_done, mem_rdata,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      output stall, wb_valid, wb_data, err
   );

   modport slave (
      output ex_valid, ALUO, Rd2, mem_read, mem_write,
      output mem_stall, mem_done, mem_rdata,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      input  stall, wb_valid, wb_data, err
   );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Access watchdog: down-counter loaded on clear, term flags the last allowed cycle.
module mem_timeout_cnt
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= CNT_W'(TIMEOUT);
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Reaching 1 while enabled means this is cycle number TIMEOUT in REQ/WAIT.
   assign term = en & (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_stage.sv
// Memory-stage controller: issues loads/stores to a multi-cycle memory and
// returns exactly one writeback beat per accepted operation.
//
// state | meaning
// IDLE  | waiting for ex_valid; pass-through and bad ops resolve here
// REQ   | mem_en high, waiting for memory to drop mem_stall
// WAIT  | request accepted, waiting for mem_done
// DONE  | one-cycle writeback beat (wb_valid, wb_data, err)
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.master bus
);

   state_t            state;
   logic              mem_en_q;
   logic              mem_wr_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wb_valid_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              err_q;

   logic              is_mem;
   logic              bad_op;
   logic              accept_mem;
   logic              cnt_en;
   logic              cnt_term;

   assign is_mem     = bus.mem_read | bus.mem_write;
   assign bad_op     = (bus.mem_read & bus.mem_write) | (bus.ALUO[0] & is_mem);
   assign accept_mem = (state == IDLE) & bus.ex_valid & is_mem & ~bad_op;
   assign cnt_en     = (state == REQ) | (state == WAIT);

   assign bus.stall     = (state != IDLE) | accept_mem;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.err       = err_q;

   mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept_mem),
      .en   (cnt_en),
      .term (cnt_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wb_valid_q <= 1'b0;
               err_q      <= 1'b0;
               if (bus.ex_valid) begin
                  if (!is_mem) begin
                     state      <= DONE;
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= bus.ALUO;
                  end else if (bad_op) begin
                     state      <= DONE;
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= '0;
                     err_q      <= 1'b1;
                  end else begin
                     state    <= REQ;
                     mem_en_q <= 1'b1;
                     mem_wr_q <= bus.mem_write;
                     addr_q   <= bus.ALUO;
                     wdata_q  <= bus.Rd2;
                  end
               end
            end
            REQ: begin
               // Completion in the accepting cycle beats a coincident timeout.
               if (!bus.mem_stall && bus.mem_done) begin
                  state      <= DONE;
                  mem_en_q   <= 1'b0;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= mem_wr_q ? '0 : bus.mem_rdata;
               end else if (cnt_term) begin
                  state      <= DONE;
                  mem_en_q   <= 1'b0;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= '0;
                  err_q      <= 1'b1;
               end else if (!bus.mem_stall) begin
                  state    <= WAIT;
                  mem_en_q <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.mem_done) begin
                  state      <= DONE;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= mem_wr_q ? '0 : bus.mem_rdata;
               end else if (cnt_term) begin
                  state      <= DONE;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= '0;
                  err_q      <= 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               wb_valid_q <= 1'b0;
               err_q      <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle op table plus multi-cycle sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, rd, wr, mstall, mdone, sel;
   logic [15:0] aluo, rd2, rdata;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_stage_if bus_a();
   mem_stage_if bus_t();

   assign bus_a.ex_valid  = ex_valid;
   assign bus_a.ALUO      = aluo;
   assign bus_a.Rd2       = rd2;
   assign bus_a.mem_read  = rd;
   assign bus_a.mem_write = wr;
   assign bus_a.mem_stall = mstall;
   assign bus_a.mem_done  = mdone;
   assign bus_a.mem_rdata = rdata;
   assign bus_t.ex_valid  = ex_valid;
   assign bus_t.ALUO      = aluo;
   assign bus_t.Rd2       = rd2;
   assign bus_t.mem_read  = rd;
   assign bus_t.mem_write = wr;
   assign bus_t.mem_stall = mstall;
   assign bus_t.mem_done  = mdone;
   assign bus_t.mem_rdata = rdata;

   mem_stage #(.TIMEOUT(32)) dut    (.clk(clk), .rst(rst), .bus(bus_a));
   mem_stage #(.TIMEOUT(4))  dut_to (.clk(clk), .rst(rst), .bus(bus_t));

   logic        o_en, o_wr, o_stall, o_wbv, o_err;
   logic [15:0] o_addr, o_wdata, o_wbd;

   always_comb begin
      o_en    = sel ? bus_t.mem_en    : bus_a.mem_en;
      o_wr    = sel ? bus_t.mem_wr    : bus_a.mem_wr;
      o_addr  = sel ? bus_t.mem_addr  : bus_a.mem_addr;
      o_wdata = sel ? bus_t.mem_wdata : bus_a.mem_wdata;
      o_stall = sel ? bus_t.stall     : bus_a.stall;
      o_wbv   = sel ? bus_t.wb_valid  : bus_a.wb_valid;
      o_wbd   = sel ? bus_t.wb_data   : bus_a.wb_data;
      o_err   = sel ? bus_t.err       : bus_a.err;
   end

   typedef struct {
      logic        ex;
      logic [15:0] aluo;
      logic [15:0] rd2;
      logic        rd;
      logic        wr;
      logic        stall;
      logic        wbv;
      logic [15:0] wbd;
      logic        err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic do_reset();
      rst = 1'b1; ex_valid = 1'b0; rd = 1'b0; wr = 1'b0; aluo = '0; rd2 = '0;
      mstall = 1'b0; mdone = 1'b0; rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Load answered by the memory in its first REQ cycle.
   task automatic do_load(input logic [15:0] addr, input logic [15:0] data);
      ex_valid = 1'b1; rd = 1'b1; aluo = addr;
      #1 chk("ld_stall_idle", o_stall, 1'b1);
      @(posedge clk); #1;
      ex_valid = 1'b0; rd = 1'b0;
      chk("ld_req_en", o_en, 1'b1);
      chk("ld_req_addr", o_addr, addr);
      chk("ld_req_wr", o_wr, 1'b0);
      chk("ld_req_stall", o_stall, 1'b1);
      chk("ld_req_wbv", o_wbv, 1'b0);
      mdone = 1'b1; rdata = data;
      @(posedge clk); #1;
      mdone = 1'b0;
      chk("ld_done_wbv", o_wbv, 1'b1);
      chk("ld_done_data", o_wbd, data);
      chk("ld_done_err", o_err, 1'b0);
      chk("ld_done_en", o_en, 1'b0);
      chk("ld_done_stall", o_stall, 1'b1);
      @(posedge clk); #1;
      chk("ld_after_wbv", o_wbv, 1'b0);
      chk("ld_after_stall", o_stall, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0};
      vecs[2] = '{1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{1'b1, 16'h0010, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
      vecs[4] = '{1'b1, 16'h0101, 16'h00A5, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
      vecs[5] = '{1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};

      sel = 1'b0;
      do_reset();
      chk("rst_en", o_en, 1'b0);
      chk("rst_wr", o_wr, 1'b0);
      chk("rst_addr", o_addr, 16'h0000);
      chk("rst_wdata", o_wdata, 16'h0000);
      chk("rst_wbv", o_wbv, 1'b0);
      chk("rst_wbd", o_wbd, 16'h0000);
      chk("rst_err", o_err, 1'b0);
      chk("rst_stall", o_stall, 1'b0);

      for (int i = 0; i < 6; i++) begin
         ex_valid = vecs[i].ex; aluo = vecs[i].aluo; rd2 = vecs[i].rd2;
         rd = vecs[i].rd; wr = vecs[i].wr;
         #1 chk($sformatf("v%0d_stall", i), o_stall, vecs[i].stall);
         @(posedge clk); #1;
         ex_valid = 1'b0; rd = 1'b0; wr = 1'b0;
         chk($sformatf("v%0d_wbv", i), o_wbv, vecs[i].wbv);
         chk($sformatf("v%0d_err", i), o_err, vecs[i].err);
         chk($sformatf("v%0d_en", i), o_en, 1'b0);
         if (vecs[i].wbv) chk($sformatf("v%0d_wbd", i), o_wbd, vecs[i].wbd);
         @(posedge clk); #1;
         chk($sformatf("v%0d_once", i), o_wbv, 1'b0);
         chk($sformatf("v%0d_en2", i), o_en, 1'b0);
      end

      do_load(16'h0040, 16'hBEEF);

      // Store: three stalled REQ cycles, one accepting cycle, two WAIT cycles.
      ex_valid = 1'b1; wr = 1'b1; aluo = 16'h0102; rd2 = 16'h00A5; mstall = 1'b1;
      #1 chk("st_stall_idle", o_stall, 1'b1);
      @(posedge clk); #1;
      ex_valid = 1'b0; wr = 1'b0; rd2 = 16'h1111; aluo = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mstall = 1'b0;
         chk($sformatf("st_req%0d_en", i), o_en, 1'b1);
         chk($sformatf("st_req%0d_wr", i), o_wr, 1'b1);
         chk($sformatf("st_req%0d_wdata", i), o_wdata, 16'h00A5);
         chk($sformatf("st_req%0d_addr", i), o_addr, 16'h0102);
         @(posedge clk); #1;
      end
      chk("st_wait_en", o_en, 1'b0);
      chk("st_wait_stall", o_stall, 1'b1);
      @(posedge clk); #1;
      chk("st_wait2_wbv", o_wbv, 1'b0);
      mdone = 1'b1;
      @(posedge clk); #1;
      mdone = 1'b0;
      chk("st_done_wbv", o_wbv, 1'b1);
      chk("st_done_err", o_err, 1'b0);
      chk("st_done_wbd", o_wbd, 16'h0000);
      @(posedge clk); #1;
      chk("st_once", o_wbv, 1'b0);

      // Timeout on the TIMEOUT=4 instance with the memory stalling forever.
      sel = 1'b1;
      do_reset();
      ex_valid = 1'b1; rd = 1'b1; aluo = 16'h0080; mstall = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0; rd = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_req%0d_en", i), o_en, 1'b1);
         chk($sformatf("to_req%0d_wbv", i), o_wbv, 1'b0);
         @(posedge clk); #1;
      end
      chk("to_wbv", o_wbv, 1'b1);
      chk("to_err", o_err, 1'b1);
      chk("to_wbd", o_wbd, 16'h0000);
      chk("to_en", o_en, 1'b0);
      mstall = 1'b0; mdone = 1'b1; rdata = 16'hDEAD;
      @(posedge clk); #1;
      chk("to_late_wbv", o_wbv, 1'b0);
      chk("to_late_err", o_err, 1'b0);
      @(posedge clk); #1;
      chk("to_idle_wbv", o_wbv, 1'b0);
      chk("to_idle_en", o_en, 1'b0);
      chk("to_idle_stall", o_stall, 1'b0);
      mdone = 1'b0;
      do_load(16'h0084, 16'h5A5A);

      // Reset while an access sits in WAIT.
      sel = 1'b0;
      do_reset();
      ex_valid = 1'b1; rd = 1'b1; aluo = 16'h0200;
      @(posedge clk); #1;
      ex_valid = 1'b0; rd = 1'b0;
      chk("rw_req_en", o_en, 1'b1);
      @(posedge clk); #1;
      chk("rw_wait_en", o_en, 1'b0);
      chk("rw_wait_stall", o_stall, 1'b1);
      rst = 1'b1; mdone = 1'b1; rdata = 16'h1111;
      @(posedge clk); #1;
      chk("rw_rst_en", o_en, 1'b0);
      chk("rw_rst_wbv", o_wbv, 1'b0);
      chk("rw_rst_stall", o_stall, 1'b0);
      rst = 1'b0; mdone = 1'b0;
      @(posedge clk); #1;
      chk("rw_post_wbv", o_wbv, 1'b0);
      do_load(16'h0204, 16'hC3C3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
